// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - start/score-memory/result bundle for argmax_classifier
interface argmax_classifier_if;
  logic       start;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       done;
  logic       valid;
  logic [3:0] class_id;
  logic [7:0] max_score;
  logic [7:0] margin;
  logic       low_conf;

  modport slave (
    input  start, rd_data,
    output rd_addr, done, valid, class_id, max_score, margin, low_conf
  );

  modport master (
    output start, rd_data,
    input  rd_addr, done, valid, class_id, max_score, margin, low_conf
  );
endinterface

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - sequential argmax over a score memory with top-two margin
// Each class costs ISSUE/WAIT/COMPARE; results latch one cycle after the last compare.
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int BASE_ADDR   = 0,
  parameter int MARGIN_TH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  argmax_classifier_if.slave    bus
);

  localparam logic [9:0] BASE_A   = 10'(BASE_ADDR);
  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
  localparam logic [7:0] TH       = 8'(MARGIN_TH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] i_q, i_d;
  logic [7:0] best_q, best_d;
  logic [7:0] second_q, second_d;
  logic [3:0] best_idx_q, best_idx_d;
  logic [9:0] rd_addr_q, rd_addr_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic [3:0] class_id_q, class_id_d;
  logic [7:0] max_score_q, max_score_d;
  logic [7:0] margin_q, margin_d;
  logic       low_conf_q, low_conf_d;
  logic [7:0] diff;

  // best >= second always holds, so this never wraps
  assign diff = best_q - second_q;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    best_d      = best_q;
    second_d    = second_q;
    best_idx_d  = best_idx_q;
    rd_addr_d   = rd_addr_q;
    done_d      = done_q;
    valid_d     = 1'b0;
    class_id_d  = class_id_q;
    max_score_d = max_score_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          i_d        = '0;
          best_d     = '0;
          second_d   = '0;
          best_idx_d = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_addr_d = BASE_A + {6'd0, i_q};
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        // strict compare keeps the lowest index on ties; an equal score lands in second
        if (bus.rd_data > best_q) begin
          second_d   = best_q;
          best_d     = bus.rd_data;
          best_idx_d = i_q;
        end else if (bus.rd_data > second_q) begin
          second_d = bus.rd_data;
        end
        if (i_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          i_d     = i_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        // done_q low marks the first FINISH cycle, where results are published
        if (!done_q) begin
          class_id_d  = best_idx_q;
          max_score_d = best_q;
          margin_d    = diff;
          low_conf_d  = (diff < TH);
          valid_d     = 1'b1;
          done_d      = 1'b1;
        end else if (!bus.start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      best_q      <= '0;
      second_q    <= '0;
      best_idx_q  <= '0;
      rd_addr_q   <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      class_id_q  <= '0;
      max_score_q <= '0;
      margin_q    <= '0;
      low_conf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      best_q      <= best_d;
      second_q    <= second_d;
      best_idx_q  <= best_idx_d;
      rd_addr_q   <= rd_addr_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      class_id_q  <= class_id_d;
      max_score_q <= max_score_d;
      margin_q    <= margin_d;
      low_conf_q  <= low_conf_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.done      = done_q;
  assign bus.valid     = valid_q;
  assign bus.class_id  = class_id_q;
  assign bus.max_score = max_score_q;
  assign bus.margin    = margin_q;
  assign bus.low_conf  = low_conf_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - directed bench for argmax_classifier (default and BASE_ADDR=32/4-class builds)
module tb_argmax_classifier;

  logic clk = 1'b0;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  logic [7:0] mem [0:1023];
  logic [9:0] seq [$];
  logic [9:0] last_addr;

  argmax_classifier_if if1 ();
  argmax_classifier_if if2 ();

  argmax_classifier u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  argmax_classifier #(.NUM_CLASSES(4), .BASE_ADDR(32), .MARGIN_TH(16))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  // one-cycle-latency synchronous score memory shared by both builds
  always @(posedge clk) begin
    if1.rd_data <= mem[if1.rd_addr];
    if2.rd_data <= mem[if2.rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pulse start (edge 0), then return the edge index of the valid pulse, or -1 on timeout
  task automatic run(input int sel, input bit toggle, output int edges);
    edges = -1;
    if (sel == 1) if1.start = 1'b1; else if2.start = 1'b1;
    tick();
    if (sel == 1) if1.start = 1'b0; else if2.start = 1'b0;
    seq.delete();
    last_addr = if2.rd_addr;
    for (int k = 1; k <= 200; k++) begin
      if (toggle && k >= 2 && k <= 20) if1.start = k[0];
      if (toggle && k == 21) if1.start = 1'b0;
      tick();
      if (if2.rd_addr != last_addr) begin
        seq.push_back(if2.rd_addr);
        last_addr = if2.rd_addr;
      end
      if ((sel == 1 && if1.valid) || (sel == 2 && if2.valid)) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic load_a();
    logic [7:0] s [10] = '{8'd3, 8'd9, 8'd200, 8'd7, 8'd0, 8'd15, 8'd180, 8'd2, 8'd1, 8'd4};
    for (int j = 0; j < 10; j++) mem[j] = s[j];
  endtask

  initial begin
    int e;
    int vcnt;
    int first_done;
    for (int j = 0; j < 1024; j++) mem[j] = 8'd0;
    rst_n = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    repeat (3) tick();

    chk("rst_done",      32'(if1.done),      32'd0);
    chk("rst_valid",     32'(if1.valid),     32'd0);
    chk("rst_class_id",  32'(if1.class_id),  32'd0);
    chk("rst_max_score", 32'(if1.max_score), 32'd0);
    chk("rst_margin",    32'(if1.margin),    32'd0);
    chk("rst_low_conf",  32'(if1.low_conf),  32'd0);
    chk("rst_rd_addr",   32'(if1.rd_addr),   32'd0);
    rst_n = 1'b1;
    tick();

    // basic ranking
    load_a();
    run(1, 1'b0, e);
    chk("a_latency",   32'(e),              32'd31);
    chk("a_valid",     32'(if1.valid),      32'd1);
    chk("a_done",      32'(if1.done),       32'd1);
    chk("a_class_id",  32'(if1.class_id),   32'd2);
    chk("a_max_score", 32'(if1.max_score),  32'd200);
    chk("a_margin",    32'(if1.margin),     32'd20);
    chk("a_low_conf",  32'(if1.low_conf),   32'd0);
    tick();
    chk("a_valid_drop", 32'(if1.valid),     32'd0);
    chk("a_done_drop",  32'(if1.done),      32'd0);
    repeat (3) tick();
    chk("a_hold_class", 32'(if1.class_id),  32'd2);
    chk("a_hold_max",   32'(if1.max_score), 32'd200);

    // all zero scores
    for (int j = 0; j < 10; j++) mem[j] = 8'd0;
    run(1, 1'b0, e);
    chk("z_latency",   32'(e),             32'd31);
    chk("z_class_id",  32'(if1.class_id),  32'd0);
    chk("z_max_score", 32'(if1.max_score), 32'd0);
    chk("z_margin",    32'(if1.margin),    32'd0);
    chk("z_low_conf",  32'(if1.low_conf),  32'd1);
    repeat (2) tick();

    // tie at 255, start toggled during the run
    for (int j = 0; j < 10; j++) mem[j] = 8'(10 * j);
    mem[4] = 8'd255;
    mem[8] = 8'd255;
    run(1, 1'b1, e);
    chk("t_latency",   32'(e),             32'd31);
    chk("t_class_id",  32'(if1.class_id),  32'd4);
    chk("t_max_score", 32'(if1.max_score), 32'd255);
    chk("t_margin",    32'(if1.margin),    32'd0);
    chk("t_low_conf",  32'(if1.low_conf),  32'd1);
    repeat (2) tick();

    // start held high for 40 cycles
    load_a();
    vcnt = 0;
    first_done = -1;
    if1.start = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (if1.valid) vcnt++;
      if (if1.done && first_done < 0) first_done = k;
    end
    chk("h_valid_count", 32'(vcnt),       32'd1);
    chk("h_done_edge",   32'(first_done), 32'd31);
    chk("h_done_held",   32'(if1.done),   32'd1);
    if1.start = 1'b0;
    tick();
    chk("h_done_clear",  32'(if1.done),   32'd0);
    run(1, 1'b0, e);
    chk("h2_latency",    32'(e),             32'd31);
    chk("h2_class_id",   32'(if1.class_id),  32'd2);
    chk("h2_margin",     32'(if1.margin),    32'd20);
    repeat (2) tick();

    // asynchronous reset mid-run
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("r_class_id",  32'(if1.class_id),  32'd0);
    chk("r_max_score", 32'(if1.max_score), 32'd0);
    chk("r_margin",    32'(if1.margin),    32'd0);
    chk("r_rd_addr",   32'(if1.rd_addr),   32'd0);
    chk("r_done",      32'(if1.done),      32'd0);
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (if1.valid || if1.done) vcnt++;
    end
    chk("r_no_valid",  32'(vcnt),          32'd0);
    run(1, 1'b0, e);
    chk("r2_latency",  32'(e),             32'd31);
    chk("r2_class_id", 32'(if1.class_id),  32'd2);

    // offset base address, four classes
    mem[32] = 8'd10;
    mem[33] = 8'd50;
    mem[34] = 8'd40;
    mem[35] = 8'd45;
    run(2, 1'b0, e);
    chk("b_latency",   32'(e),             32'd13);
    chk("b_seq_len",   32'(seq.size()),    32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < seq.size()) chk("b_rd_addr", 32'(seq[j]), 32'(32 + j));
    end
    chk("b_class_id",  32'(if2.class_id),  32'd1);
    chk("b_max_score", 32'(if2.max_score), 32'd50);
    chk("b_margin",    32'(if2.margin),    32'd5);
    chk("b_low_conf",  32'(if2.low_conf),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
